// File: rtl/bip_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bip_dmem_pkg
// Description : Shared types and request codes for the BIP data memory.
// Revision    : 1.0 - initial release
// ============================================================================
package bip_dmem_pkg;

    // Controller state: post-reset clear sweep, then normal service.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } dmem_state_e;

    // Request codes, formed as {Rd, Wr}.
    localparam logic [1:0] REQ_NONE = 2'b00;
    localparam logic [1:0] REQ_WR   = 2'b01;
    localparam logic [1:0] REQ_RD   = 2'b10;
    localparam logic [1:0] REQ_BAD  = 2'b11;

endpackage : bip_dmem_pkg
`default_nettype wire

// File: rtl/bip_dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : bip_dmem_array
// Description : Plain single-port falling-edge RAM, no reset, asynchronous
//               read. Out-of-range addresses never write and read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int              IDX_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0]  idx;
    logic              in_range;

    // The extra leading zero keeps the compare unsigned and full width.
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign idx      = addr[IDX_W-1:0];

    // Storage is written on the falling edge, matching the controller.
    always_ff @(negedge clk) begin
        if (we && in_range) begin
            mem_q[idx] <= wdata;
        end
    end

    assign rdata = in_range ? mem_q[idx] : '0;

endmodule : bip_dmem_array
`default_nettype wire

// File: rtl/bip_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : bip_data_memory
// Description : Parametrised BIP data memory with post-reset clear sweep,
//               Ready flag and one-cycle Err pulse on illegal requests.
//               Optional macro DMEM_ADDR_ERR_EN: out-of-range reads/writes
//               also pulse Err.
// Revision    : 1.0 - initial release
// ============================================================================
module bip_data_memory
    import bip_dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] In_data,
    output logic [DATA_W-1:0] Out_data,
    output logic              Ready,
    output logic              Err
);

    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
`ifdef DMEM_ADDR_ERR_EN
    localparam logic ADDR_ERR_EN = 1'b1;
`else
    localparam logic ADDR_ERR_EN = 1'b0;
`endif

    dmem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q,   ptr_d;
    logic [DATA_W-1:0] out_q,   out_d;
    logic              err_q,   err_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        req;
    logic              in_range;

    assign req      = {Rd, Wr};
    assign in_range = ({1'b0, Addr} < DEPTH_X);

    bip_dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Next-state, array port steering and output register inputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        out_d     = out_q;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = Addr;
        mem_wdata = In_data;
        case (state_q)
            ST_CLEAR: begin
                // The sweep owns the array port; CPU requests are ignored.
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = '0;
                out_d     = '0;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                case (req)
                    REQ_WR: begin
                        if (in_range) begin
                            mem_we = 1'b1;
                            out_d  = In_data;
                        end else begin
                            err_d = ADDR_ERR_EN;
                        end
                    end
                    REQ_RD: begin
                        out_d = in_range ? mem_rdata : '0;
                        err_d = ADDR_ERR_EN & ~in_range;
                    end
                    REQ_BAD: begin
                        err_d = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // State and output registers, updated on the falling edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign Out_data = out_q;
    assign Ready    = (state_q == ST_IDLE);
    assign Err      = err_q;

endmodule : bip_data_memory
`default_nettype wire
